// File: rtl/step_controller.sv
// step_controller: single-step / free-run / breakpoint clock-enable generator
// for a small processor FSM.
//
// Ports:
//   clock      system clock, all state on rising edge
//   reset      asynchronous, active-high
//   key_n      raw active-low step pushbutton (asynchronous, bouncy)
//   run        level, 1 requests free-run
//   bp_en      enables the PC breakpoint
//   bp_addr    breakpoint address
//   pc         current processor PC
//   cpu_en     one-cycle clock enable advancing the processor one state
//   mode       00 IDLE, 01 RUN, 10 HALT
//   step_count saturating count of cpu_en pulses since reset
module step_controller #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned RUN_DIV   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_n,
  input  logic        run,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc,
  output logic        cpu_en,
  output logic [1:0]  mode,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [15:0] DB_LAST  = 16'(DB_CYCLES - 1);
  localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

  logic        sync1_q, sync2_q;
  logic        db_q, db_d;
  logic        db_prev_q;
  logic        press_q, press_d;
  logic [15:0] stab_q, stab_d;
  logic [15:0] div_q, div_d;
  state_e      state_q, state_d;
  logic        cpu_en_q, cpu_en_d;
  logic [15:0] step_count_q, step_count_d;
  logic        bp_hit;

  assign bp_hit = bp_en && (pc == bp_addr);

  // Debounce: the level only follows the synchronized key after DB_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    db_d   = db_q;
    stab_d = '0;
    if (sync2_q != db_q) begin
      if (stab_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        stab_d = stab_q + 16'd1;
      end
    end
  end

  // Press is a debounced 1->0 edge, registered once more so the response
  // lands DB_CYCLES+3 edges after the key is first sampled low.
  assign press_d = db_prev_q & ~db_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cpu_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d    = '0;
        cpu_en_d = press_q;
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        // run=0 wins over a breakpoint landing on the same cycle
        if (!run) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bp_hit) state_d  = ST_HALT;
          else        cpu_en_d = 1'b1;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      ST_HALT: begin
        div_d = '0;
        if (press_q) begin
          cpu_en_d = 1'b1;
          state_d  = run ? ST_RUN : ST_IDLE;
        end else if (!run) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_comb begin
    step_count_d = step_count_q;
    if (cpu_en_d && (step_count_q != '1)) step_count_d = step_count_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      db_q         <= 1'b1;
      db_prev_q    <= 1'b1;
      press_q      <= 1'b0;
      stab_q       <= '0;
      div_q        <= '0;
      state_q      <= ST_IDLE;
      cpu_en_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      sync1_q      <= key_n;
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_prev_q    <= db_q;
      press_q      <= press_d;
      stab_q       <= stab_d;
      div_q        <= div_d;
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      step_count_q <= step_count_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign mode       = state_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_controller.sv
// Testbench for step_controller: directed scenarios plus randomized key,
// run and breakpoint activity, compared every cycle against a behavioural
// model of the debounce window, press latency and mode rules.
module tb_step_controller;

  localparam int DB  = 4;
  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        key_n;
  logic        run;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  pc;
  logic        cpu_en;
  logic [1:0]  mode;
  logic [15:0] step_count;

  step_controller #(.DB_CYCLES(DB), .RUN_DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .run        (run),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .mode       (mode),
    .step_count (step_count)
  );

  always #5 clock = ~clock;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic   hist[$];     // key_n as sampled at each edge since reset
  logic   m_db;
  int     t;
  int     m_press_edge;
  int     m_mode;      // 0 IDLE, 1 RUN, 2 HALT
  int     m_entry;     // edge at which RUN was entered
  int     m_cnt;
  logic   m_en;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DB + 1; i++) hist.push_back(1'b1);
    m_db = 1'b1;
    t = 0;
    m_press_edge = -1;
    m_mode = 0;
    m_entry = 0;
    m_cnt = 0;
    m_en = 1'b0;
  endtask

  task automatic model_step();
    logic all_diff;
    logic press;
    if (reset) begin
      model_reset();
      return;
    end
    t++;
    hist.push_back(key_n);
    while (hist.size() > DB + 2) void'(hist.pop_front());
    // hist[0..DB-1] are the samples reaching the debouncer through the
    // two-stage synchronizer: edges t-DB-1 .. t-2
    all_diff = 1'b1;
    for (int i = 0; i < DB; i++) if (hist[i] == m_db) all_diff = 1'b0;
    press = (m_press_edge == t);
    if (all_diff) begin
      m_db = ~m_db;
      if (m_db == 1'b0) m_press_edge = t + 2;
    end
    m_en = 1'b0;
    case (m_mode)
      0: begin
        if (press) m_en = 1'b1;
        if (run) begin m_mode = 1; m_entry = t; end
      end
      1: begin
        if (!run) m_mode = 0;
        else if (((t - m_entry) % DIV) == 0) begin
          if (bp_en && pc == bp_addr) m_mode = 2;
          else m_en = 1'b1;
        end
      end
      default: begin
        if (press) begin
          m_en = 1'b1;
          if (run) begin m_mode = 1; m_entry = t; end
          else m_mode = 0;
        end else if (!run) m_mode = 0;
      end
    endcase
    if (m_en && m_cnt < 65535) m_cnt++;
  endtask

  // ---------------- cycle monitor ----------------
  logic prev_en = 1'b0;
  initial begin
    forever begin
      @(posedge clock);
      model_step();
      #1;
      check("cpu_en", 16'(cpu_en), 16'(m_en));
      check("mode", 16'(mode), 16'(m_mode));
      check("step_count", step_count, 16'(m_cnt));
      check("cpu_en_adjacent", 16'(cpu_en & prev_en), 16'd0);
      prev_en = cpu_en;
    end
  end

  // ---------------- stimulus ----------------
  int          lat;
  int          npulse;
  int unsigned len;
  logic        key_lvl;
  logic [1:0]  mode_at;

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (cpu_en) n++;
    end
  endtask

  initial begin
    reset = 1'b1; key_n = 1'b1; run = 1'b0; bp_en = 1'b0;
    bp_addr = 8'h05; pc = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_cpu_en", 16'(cpu_en), 16'd0);
    check("reset_mode", 16'(mode), 16'd0);
    check("reset_step_count", step_count, 16'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // bounce low 2 cycles, then held low: one pulse DB+3 edges later
    key_n = 1'b0;
    repeat (2) @(negedge clock);
    key_n = 1'b1;
    repeat (2) @(negedge clock);
    key_n = 1'b0;
    lat = 0; npulse = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clock); #1;
      if (cpu_en) begin
        npulse++;
        if (lat == 0) lat = i - 1;
      end
    end
    check("press_latency", 16'(lat), 16'(DB + 3));
    check("press_pulses", 16'(npulse), 16'd1);
    check("press_step_count", step_count, 16'd1);
    @(negedge clock); key_n = 1'b1;
    count_pulses(15, npulse);
    check("release_pulses", 16'(npulse), 16'd0);

    // randomized key bursts, run toggles, breakpoints and occasional resets
    key_lvl = 1'b1;
    for (int b = 0; b < 200; b++) begin
      len = $urandom_range(1, 12);
      key_lvl = ~key_lvl;
      if ($urandom_range(0, 9) == 0) run = ~run;
      bp_addr = 8'($urandom_range(0, 7));
      for (int c = 0; c < int'(len); c++) begin
        @(negedge clock);
        key_n = key_lvl;
        bp_en = 1'($urandom_range(0, 1));
        pc = 8'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
      end
    end
    @(negedge clock);
    key_n = 1'b1; run = 1'b0; bp_en = 1'b0; pc = 8'h00; bp_addr = 8'h05;
    repeat (3 * DB + 10) @(negedge clock);

    // free-run, no breakpoint: one pulse every DIV cycles
    run = 1'b1;
    count_pulses(40, npulse);
    check("run_pulses_in_range", 16'(npulse >= 9 && npulse <= 11), 16'd1);
    @(negedge clock); run = 1'b0;
    repeat (5) @(negedge clock);

    // breakpoint halts RUN; a press single-steps and resumes RUN
    bp_en = 1'b1; bp_addr = 8'h05; pc = 8'h00; run = 1'b1;
    repeat (10) @(negedge clock);
    pc = 8'h05;
    repeat (10) @(negedge clock);
    check("bp_mode_halt", 16'(mode), 16'd2);
    count_pulses(20, npulse);
    check("bp_halt_pulses", 16'(npulse), 16'd0);
    @(negedge clock); key_n = 1'b0;
    npulse = 0; mode_at = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (cpu_en) begin npulse++; mode_at = mode; end
    end
    check("bp_step_pulses", 16'(npulse), 16'd1);
    check("bp_step_mode", 16'(mode_at), 16'd1);
    @(negedge clock); key_n = 1'b1; run = 1'b0; bp_en = 1'b0;
    repeat (3 * DB + 5) @(negedge clock);

    // run falls on the very cycle a breakpoint would hit
    bp_en = 1'b1; pc = 8'h05; run = 1'b1;
    repeat (DIV) @(posedge clock);
    @(negedge clock); run = 1'b0;
    @(posedge clock); #1;
    check("runfall_bp_mode", 16'(mode), 16'd0);
    check("runfall_bp_cpu_en", 16'(cpu_en), 16'd0);
    @(negedge clock); bp_en = 1'b0;
    repeat (3) @(negedge clock);

    // step_count saturation
    run = 1'b1;
    repeat (3) @(negedge clock);
    force dut.step_count_q = 16'hFFFC;
    m_cnt = 32'h0000FFFC;
    #1 release dut.step_count_q;
    count_pulses(40, npulse);
    check("sat_pulses_seen", 16'(npulse >= 8), 16'd1);
    check("sat_step_count", step_count, 16'hFFFF);
    @(negedge clock); run = 1'b0;
    repeat (3) @(negedge clock);

    // reset two cycles into a debounce window discards the press
    key_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1; key_n = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_cpu_en", 16'(cpu_en), 16'd0);
    check("rst_mid_mode", 16'(mode), 16'd0);
    check("rst_mid_step_count", step_count, 16'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    count_pulses(20, npulse);
    check("rst_mid_pulses", 16'(npulse), 16'd0);
    check("rst_after_step_count", step_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
